ioctl_upload_server: RTL and testbench
======================================

# ioctl_upload_server

Serves the HPS-side upload (save) stream for arcade cores, the read-back counterpart of the ROM download path. On each HPS byte request it pauses the game core, fetches the requested byte from a core RAM read port (high-score / NVRAM area) and returns it on the ioctl read-data bus with a wait handshake. It sits between `hps_io` and the game module, beside the existing download wiring.

## Interface
Parameters:
- `ADDR_W`, 10: core RAM address width.
- `SIZE`, 1024: number of bytes exposed; must satisfy `SIZE <= 2**ADDR_W`.
- `RAM_LAT`, 2: cycles from `ram_rd` pulse to valid `ram_q` (1..7).

Ports:
- `clk_sys` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: upload session active (level, from `hps_io`).
- `ioctl_rd` in 1: one-cycle byte request.
- `ioctl_addr` in 25: byte address, valid with `ioctl_rd`.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: HPS must not issue `ioctl_rd` while high.
- `pause_req` out 1: request core halt.
- `pause_ack` in 1: core halted; RAM port free.
- `ram_addr` out ADDR_W: RAM read address.
- `ram_rd` out 1: one-cycle read strobe.
- `ram_q` in 8: RAM read data.
- `err` out 1: sticky protocol-error flag.

## Operation
- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `pause_req`=0, `ram_rd`=0, `ram_addr`=0, `err`=0, state IDLE, latency counter 0.
- States:
  - IDLE: when `ioctl_upload`=1, go to PAUSE and set `err`=0.
  - PAUSE: `pause_req`=1, `ioctl_wait`=1. When `pause_ack`=1, go to READY and drop `ioctl_wait`.
  - READY: `pause_req`=1, `ioctl_wait`=0. On `ioctl_rd`:
    - if `ioctl_addr < SIZE`: go to READ.
    - otherwise: go to DONE with byte 8'hFF and no RAM access (except the checksum address, see Configuration).
  - READ: issue the `ram_rd` pulse with `ram_addr = ioctl_addr[ADDR_W-1:0]`, count `RAM_LAT` cycles, capture `ram_q`, go to DONE.
  - DONE: load `ioctl_din`, drop `ioctl_wait`, return to READY.
- If `ioctl_upload` falls in any non-IDLE state, go to RELEASE. RELEASE drives `ram_rd`=0, `ioctl_wait`=0 and `pause_req`=0 on the next cycle, does not update `ioctl_din`, then goes to IDLE.
- If `pause_ack` falls during READY/READ/DONE: set `err`, let any pending read complete, then go to PAUSE.
- An `ioctl_rd` received while `ioctl_wait`=1 or outside a session is ignored and sets `err`.
- `ioctl_addr` bits above `ADDR_W` take part only in the `< SIZE` comparison. Full 25-bit compare, no wrap-around.

## Timing
- `ioctl_rd` is sampled at cycle T in READY.
- T+1: `ioctl_wait`=1, `ram_rd`=1 (for one cycle only), `ram_addr` valid. `ram_addr` holds until the next read.
- `ram_q` is sampled at T+1+`RAM_LAT`.
- T+2+`RAM_LAT`: `ioctl_din` updated and `ioctl_wait`=0, registered at the same edge.
- Out-of-range request: `ioctl_wait` high at T+1 only; `ioctl_din`=FF and `ioctl_wait`=0 at T+2.
- Session start: `pause_req` and `ioctl_wait` rise 1 cycle after `ioctl_upload` rises. READY is entered 1 cycle after `pause_ack` is sampled high.
- `reset_n` low clears all outputs immediately, including mid-read and mid-pause. State after reset release is IDLE even if `ioctl_upload` is still high; PAUSE is entered on the following cycle.

## Configuration
- `UPLOAD_CHECKSUM_EN` defined:
  - an 8-bit running sum is kept of every byte returned from RAM during the session, cleared on session start;
  - a request at address `SIZE` returns the two's complement of that sum (`(~sum)+1`), with out-of-range latency;
  - addresses above `SIZE` return FF.
- `UPLOAD_CHECKSUM_EN` undefined: no accumulator; address `SIZE` returns FF like every other out-of-range address.

## Test plan
- RAM[5]=8'hA5, `RAM_LAT`=2, session running, `ioctl_rd` with `ioctl_addr`=5 at T -> `ram_rd` pulse at T+1 with `ram_addr`=5; `ioctl_din`=A5 and `ioctl_wait`=0 at T+4.
- `ioctl_upload` rises, `pause_ack` delayed 10 cycles -> `pause_req`=1 from +1 onward; `ioctl_wait`=1 for exactly the PAUSE interval, drops 1 cycle after `pause_ack` is sampled.
- Read of address 1024 with `SIZE`=1024, macro undefined -> no `ram_rd`; `ioctl_din`=FF at T+2.
- Macro defined: read bytes 0..3 = 01,02,03,04, then address 1024 -> `ioctl_din`=8'hF6.
- Second `ioctl_rd` at T+2 of a pending read -> ignored, `err`=1, first read still returns correct data at T+4.
- `ioctl_upload` drops at T+2 of a read -> `pause_req`=0 and `ioctl_wait`=0 next cycle, `ioctl_din` unchanged. `reset_n` pulsed low mid-READ -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server: serves HPS upload (save) byte requests from core RAM.
// Optional feature macro: UPLOAD_CHECKSUM_EN (byte at address SIZE = two's complement checksum).
module ioctl_upload_server #(
    parameter int ADDR_W  = 10,
    parameter int SIZE    = 1024,
    parameter int RAM_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, PAUSE, READY, READ, DONE, RELEASE
    } state_t;

    localparam logic [24:0] SIZE_W = 25'(SIZE);
    localparam logic [2:0]  LAT_W  = 3'(RAM_LAT);

    state_t     state;
    logic [2:0] cnt;
    logic       lost;
    logic [7:0] dbyte;
    logic [7:0] oor_byte;
    logic       in_range;
    logic       rd_bad;
    logic       rd_cap;

    assign in_range = ioctl_addr < SIZE_W;
    assign rd_bad   = ioctl_rd && (ioctl_wait || !ioctl_upload ||
                                   state == IDLE || state == RELEASE);
    assign rd_cap   = state == READ && ioctl_upload && cnt == LAT_W;

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] sum;

    // Running sum of RAM bytes returned during the current session
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            sum <= 8'd0;
        else if (state == IDLE && ioctl_upload)
            sum <= 8'd0;
        else if (rd_cap)
            sum <= sum + ram_q;
    end

    assign oor_byte = (ioctl_addr == SIZE_W) ? (~sum + 8'd1) : 8'hFF;
`else
    assign oor_byte = 8'hFF;
`endif

    // Session / request sequencer with registered handshake outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            lost       <= 1'b0;
            dbyte      <= 8'd0;
            ioctl_din  <= 8'd0;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            err        <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            if (state != IDLE && state != RELEASE && !ioctl_upload) begin
                state      <= RELEASE;
                pause_req  <= 1'b0;
                ioctl_wait <= 1'b0;
                lost       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ioctl_upload) begin
                            state      <= PAUSE;
                            pause_req  <= 1'b1;
                            ioctl_wait <= 1'b1;
                            err        <= 1'b0;
                            lost       <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (pause_ack) begin
                            state      <= READY;
                            ioctl_wait <= 1'b0;
                        end
                    end
                    READY: begin
                        if (!pause_ack) begin
                            state      <= PAUSE;
                            ioctl_wait <= 1'b1;
                            err        <= 1'b1;
                        end else if (ioctl_rd) begin
                            ioctl_wait <= 1'b1;
                            if (in_range) begin
                                state    <= READ;
                                ram_rd   <= 1'b1;
                                ram_addr <= ioctl_addr[ADDR_W-1:0];
                                cnt      <= 3'd0;
                            end else begin
                                state <= DONE;
                                dbyte <= oor_byte;
                            end
                        end
                    end
                    READ, DONE: begin
                        if (!pause_ack) begin
                            err  <= 1'b1;
                            lost <= 1'b1;
                        end
                        if (state == READ && cnt != LAT_W) begin
                            cnt <= cnt + 3'd1;
                        end else begin
                            ioctl_din <= (state == READ) ? ram_q : dbyte;
                            if (lost || !pause_ack) begin
                                state      <= PAUSE;
                                ioctl_wait <= 1'b1;
                                lost       <= 1'b0;
                            end else begin
                                state      <= READY;
                                ioctl_wait <= 1'b0;
                            end
                        end
                    end
                    RELEASE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (rd_bad)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ioctl_upload_server.sv
// tb_ioctl_upload_server: directed bench with expected-byte scoreboard.
// Expectation at address SIZE follows UPLOAD_CHECKSUM_EN.
module tb_ioctl_upload_server;

    localparam int ADDR_W  = 10;
    localparam int SIZE    = 1024;
    localparam int RAM_LAT = 2;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_upload = 1'b0;
    logic              ioctl_rd = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              pause_req;
    logic              pause_ack = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q = 8'd0;
    logic              err;

    logic [7:0] mem [0:SIZE-1];
    logic [7:0] p1 = 8'd0;
    logic [7:0] sb [$];
    logic [7:0] cs_exp;
    int errors = 0;
    int checks = 0;
    int k;

    ioctl_upload_server #(
        .ADDR_W (ADDR_W),
        .SIZE   (SIZE),
        .RAM_LAT(RAM_LAT)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_q       (ram_q),
        .err         (err)
    );

    always #5 clk_sys = ~clk_sys;

    // Two-cycle read RAM model
    always @(posedge clk_sys) begin
        if (ram_rd) p1 <= mem[ram_addr];
        ram_q <= p1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input logic [24:0] a, input logic [7:0] exp,
                            input logic rng);
        int lat;
        logic [7:0] e;
        sb.push_back(exp);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("rd_wait_t1", ioctl_wait, 1);
        chk("rd_strobe_t1", ram_rd, rng);
        if (rng) chk("rd_addr_t1", ram_addr, a[ADDR_W-1:0]);
        lat = 1;
        while (ioctl_wait && lat < 12) begin
            @(negedge clk_sys);
            lat++;
        end
        chk("rd_latency", lat, rng ? 2 + RAM_LAT : 2);
        e = sb.pop_front();
        chk("rd_data", ioctl_din, e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_din"}, ioctl_din, 0);
        chk({tag, "_wait"}, ioctl_wait, 0);
        chk({tag, "_preq"}, pause_req, 0);
        chk({tag, "_ramrd"}, ram_rd, 0);
        chk({tag, "_ramaddr"}, ram_addr, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        mem[5] = 8'hA5; mem[7] = 8'h77; mem[1023] = 8'h3C;
`ifdef UPLOAD_CHECKSUM_EN
        cs_exp = 8'hF6;
`else
        cs_exp = 8'hFF;
`endif
        #12;
        chk_all_zero("reset");
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("start_preq", pause_req, 1);
        chk("start_wait", ioctl_wait, 1);
        repeat (9) begin
            @(negedge clk_sys);
            chk("pause_wait_held", ioctl_wait, 1);
        end
        pause_ack = 1'b1;
        @(negedge clk_sys);
        chk("ready_wait", ioctl_wait, 0);
        chk("ready_preq", pause_req, 1);
        chk("ready_err", err, 0);

        read_chk(25'd0, 8'h01, 1'b1);
        read_chk(25'd1, 8'h02, 1'b1);
        read_chk(25'd2, 8'h03, 1'b1);
        read_chk(25'd3, 8'h04, 1'b1);
        read_chk(25'd1024, cs_exp, 1'b0);
        read_chk(25'd1025, 8'hFF, 1'b0);
        read_chk(25'h1000005, 8'hFF, 1'b0);
        read_chk(25'd1023, 8'h3C, 1'b1);
        read_chk(25'd5, 8'hA5, 1'b1);
        chk("no_err_yet", err, 0);

        sb.push_back(8'h77);
        ioctl_addr = 25'd7;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'd3;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("busy_rd_err", err, 1);
        chk("busy_rd_wait", ioctl_wait, 1);
        chk("busy_rd_nostrobe", ram_rd, 0);
        @(negedge clk_sys);
        chk("busy_first_wait", ioctl_wait, 0);
        chk("busy_first_data", ioctl_din, sb.pop_front());

        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("drop_preq", pause_req, 0);
        chk("drop_wait", ioctl_wait, 0);
        chk("drop_din", ioctl_din, 8'h77);
        @(negedge clk_sys);
        chk("drop_din_later", ioctl_din, 8'h77);

        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        chk("restart_wait", ioctl_wait, 1);
        k = 0;
        while (ioctl_wait && k < 10) begin
            @(negedge clk_sys);
            k++;
        end
        chk("restart_ready", ioctl_wait, 0);
        chk("restart_err_clr", err, 0);

        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk("midread_strobe", ram_rd, 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk_sys);
        reset_n = 1'b1;
        chk("post_rst_preq", pause_req, 0);
        @(negedge clk_sys);
        chk("post_rst_pause_preq", pause_req, 1);
        chk("post_rst_pause_wait", ioctl_wait, 1);
        @(negedge clk_sys);
        chk("post_rst_ready", ioctl_wait, 0);

        pause_ack = 1'b0;
        @(negedge clk_sys);
        chk("ack_lost_err", err, 1);
        chk("ack_lost_wait", ioctl_wait, 1);
        pause_ack = 1'b1;
        @(negedge clk_sys);
        chk("ack_back_ready", ioctl_wait, 0);
        read_chk(25'd2, 8'h03, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
